// File: rtl/execute_mem_stage.sv
// Execute stage and EX/MEM pipeline latch for the 16-bit WISC pipeline:
// operand forwarding, ALU, Z/V/N flag register, stall/flush handling.
module execute_mem_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          valid_in,
  input  logic [3:0]    opcode_in,
  input  logic [DW-1:0] rd1_in,
  input  logic [DW-1:0] rd2_in,
  input  logic [DW-1:0] sign_ext_in,
  input  logic [DW-1:0] pc_in,
  input  logic [RW-1:0] dstReg_in,
  input  logic [1:0]    fwdA_sel,
  input  logic [1:0]    fwdB_sel,
  input  logic [DW-1:0] wb_data_in,
  output logic [DW-1:0] alu_out,
  output logic [DW-1:0] store_data_out,
  output logic [RW-1:0] dstReg_out,
  output logic          reg_write_out,
  output logic          mem_read_out,
  output logic          mem_write_out,
  output logic          valid_out,
  output logic [2:0]    flags_out
);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
    OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7,
    OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LHB = 4'hA, OP_LLB = 4'hB,
    OP_B   = 4'hC, OP_BR  = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF
  } op_e;

  // Result is {overflow, clamped value}; a 1-bit sign extension exposes overflow.
  function automatic logic [DW:0] sat_addsub(input logic [DW-1:0] a, b, input logic sub);
    logic [DW:0]   ext;
    logic [DW-1:0] res;
    logic          ovf;
    ext = sub ? ({a[DW-1], a} - {b[DW-1], b}) : ({a[DW-1], a} + {b[DW-1], b});
    ovf = ext[DW] ^ ext[DW-1];
    if (ovf) res = ext[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else     res = ext[DW-1:0];
    return {ovf, res};
  endfunction

  function automatic logic [15:0] paddsb(input logic [15:0] a, b);
    logic [15:0] res;
    logic [3:0]  s;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      s = a[4*i +: 4] + b[4*i +: 4];
      if (a[4*i+3] == b[4*i+3] && s[3] != a[4*i+3])
        res[4*i +: 4] = a[4*i+3] ? 4'h8 : 4'h7;
      else
        res[4*i +: 4] = s;
    end
    return res;
  endfunction

  function automatic logic [15:0] red(input logic [15:0] a, b);
    logic [9:0] sum;
    sum = {{2{a[15]}}, a[15:8]} + {{2{a[7]}}, a[7:0]}
        + {{2{b[15]}}, b[15:8]} + {{2{b[7]}}, b[7:0]};
    return {{6{sum[9]}}, sum};
  endfunction

  logic [DW-1:0]   a_op, b_op, result;
  logic [DW:0]     sum_res, diff_res;
  logic [2*DW-1:0] rot_full;
  logic [3:0]      shamt;
  logic            ovf, writes_reg, is_lw, is_sw, upd_zvn, upd_z, zero;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    unique case (fwdA_sel)
      2'b01:   a_op = alu_out;
      2'b10:   a_op = wb_data_in;
      default: a_op = rd1_in;
    endcase
    unique case (fwdB_sel)
      2'b01:   b_op = alu_out;
      2'b10:   b_op = wb_data_in;
      default: b_op = rd2_in;
    endcase

    shamt      = sign_ext_in[3:0];
    sum_res    = sat_addsub(a_op, b_op, 1'b0);
    diff_res   = sat_addsub(a_op, b_op, 1'b1);
    rot_full   = {a_op, a_op} >> shamt;
    result     = '0;
    ovf        = 1'b0;
    writes_reg = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    upd_zvn    = 1'b0;
    upd_z      = 1'b0;

    case (op_e'(opcode_in))
      OP_ADD:    begin result = sum_res[DW-1:0];  ovf = sum_res[DW];  writes_reg = 1'b1; upd_zvn = 1'b1; end
      OP_SUB:    begin result = diff_res[DW-1:0]; ovf = diff_res[DW]; writes_reg = 1'b1; upd_zvn = 1'b1; end
      OP_XOR:    begin result = a_op ^ b_op;                       writes_reg = 1'b1; upd_z = 1'b1; end
      OP_RED:    begin result = red(a_op, b_op);                   writes_reg = 1'b1; end
      OP_SLL:    begin result = a_op << shamt;                     writes_reg = 1'b1; upd_z = 1'b1; end
      OP_SRA:    begin result = $signed(a_op) >>> shamt;           writes_reg = 1'b1; upd_z = 1'b1; end
      OP_ROR:    begin result = rot_full[DW-1:0];                  writes_reg = 1'b1; upd_z = 1'b1; end
      OP_PADDSB: begin result = paddsb(a_op, b_op);                writes_reg = 1'b1; end
      OP_LW:     begin result = a_op + sign_ext_in;                writes_reg = 1'b1; is_lw = 1'b1; end
      OP_SW:     begin result = a_op + sign_ext_in;                is_sw = 1'b1; end
      OP_LHB:    begin result = {sign_ext_in[7:0], a_op[7:0]};     writes_reg = 1'b1; end
      OP_LLB:    begin result = {a_op[15:8], sign_ext_in[7:0]};    writes_reg = 1'b1; end
      OP_PCS:    begin result = pc_in;                             writes_reg = 1'b1; end
      default:   result = '0;
    endcase
    zero = (result == '0);
  end

  // Bubbles (flush, or an invalid instruction while not stalled) clear the latch but keep the flags.
  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_out        <= '0;
      store_data_out <= '0;
      dstReg_out     <= '0;
      reg_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      valid_out      <= 1'b0;
      flags_out      <= '0;
    end else if (flush || (!stall && !valid_in)) begin
      alu_out        <= '0;
      store_data_out <= '0;
      dstReg_out     <= '0;
      reg_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      valid_out      <= 1'b0;
    end else if (!stall) begin
      alu_out        <= result;
      store_data_out <= b_op;
      dstReg_out     <= dstReg_in;
      reg_write_out  <= writes_reg;
      mem_read_out   <= is_lw;
      mem_write_out  <= is_sw;
      valid_out      <= 1'b1;
      if (upd_zvn)    flags_out <= {zero, ovf, result[DW-1]};
      else if (upd_z) flags_out[2] <= zero;
    end
  end

endmodule
